// File: rtl/frame_addr_pkg.sv
// Shared defaults and swap-FSM encoding for the frame address generator.
package frame_addr_pkg;

  localparam int unsigned DEF_H_ACTIVE    = 640;
  localparam int unsigned DEF_V_ACTIVE    = 480;
  localparam int unsigned DEF_SCALE_SHIFT = 1;
  localparam int unsigned DEF_ADDR_W      = 19;
  localparam int unsigned COORD_W         = 10;

  typedef enum logic {
    ST_IDLE    = 1'b0,
    ST_PENDING = 1'b1
  } swap_state_e;

endpackage

// File: rtl/buf_swap_ctrl.sv
// Double-buffer swap control: arms on swap_req, toggles buf_sel on the next frame-start sample.
module buf_swap_ctrl
  import frame_addr_pkg::*;
(
  input  logic clk,
  input  logic reset,
  input  logic i_pix_en,
  input  logic i_frame_start,
  input  logic i_swap_req,
  output logic o_buf_sel,
  output logic o_buf_use_c,
  output logic o_swap_ack
);

  swap_state_e r_state;
  swap_state_e w_state_nxt;
  logic        w_fs_sample;
  logic        w_swap_now;
  logic        r_buf_sel;
  logic        r_ack_s1;
  logic        r_swap_ack;

  assign w_fs_sample = i_pix_en & i_frame_start;

  always_ff @(posedge clk) begin
    if (reset) r_state <= ST_IDLE;
    else       r_state <= w_state_nxt;
  end

  // A request coinciding with a frame start in IDLE is consumed immediately.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE:    if (i_swap_req && !w_fs_sample) w_state_nxt = ST_PENDING;
      ST_PENDING: if (w_fs_sample)                w_state_nxt = ST_IDLE;
      default:    w_state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    w_swap_now = 1'b0;
    case (r_state)
      ST_IDLE:    w_swap_now = i_swap_req & w_fs_sample;
      ST_PENDING: w_swap_now = w_fs_sample;
      default:    w_swap_now = 1'b0;
    endcase
  end

  // Ack trails the swap by two cycles so it lines up with the address pipeline.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_buf_sel  <= 1'b0;
      r_ack_s1   <= 1'b0;
      r_swap_ack <= 1'b0;
    end else begin
      r_buf_sel  <= r_buf_sel ^ w_swap_now;
      r_ack_s1   <= w_swap_now;
      r_swap_ack <= r_ack_s1;
    end
  end

  assign o_buf_sel   = r_buf_sel;
  assign o_buf_use_c = r_buf_sel ^ w_swap_now;
  assign o_swap_ack  = r_swap_ack;

endmodule

// File: rtl/frame_addr_gen.sv
// Two-stage pixel-to-framebuffer address pipeline with double-buffer base select.
// Optional horizontal mirroring when FRAME_ADDR_MIRROR_EN is defined.
module frame_addr_gen
  import frame_addr_pkg::*;
#(
  parameter int unsigned H_ACTIVE    = DEF_H_ACTIVE,
  parameter int unsigned V_ACTIVE    = DEF_V_ACTIVE,
  parameter int unsigned SCALE_SHIFT = DEF_SCALE_SHIFT,
  parameter int unsigned ADDR_W      = DEF_ADDR_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [9:0]        hcount,
  input  logic [9:0]        vcount,
  input  logic              pix_en,
  input  logic              swap_req,
  output logic [ADDR_W-1:0] addr,
  output logic              addr_valid,
  output logic              in_active,
  output logic              buf_sel,
  output logic              swap_ack
);

  localparam int unsigned       CALC_W      = 32;
  localparam int unsigned       H_STRIDE    = H_ACTIVE >> SCALE_SHIFT;
  localparam int unsigned       FRAME_WORDS = H_STRIDE * (V_ACTIVE >> SCALE_SHIFT);
  localparam longint unsigned   BUF_SPAN    = 64'(2) * 64'(FRAME_WORDS);
  localparam longint unsigned   ADDR_SPAN   = 64'(1) << ADDR_W;

  if (BUF_SPAN > ADDR_SPAN) begin : g_addr_chk
    $error("frame_addr_gen: ADDR_W too small for two frame buffers");
  end
  if (SCALE_SHIFT > 3) begin : g_scale_chk
    $error("frame_addr_gen: SCALE_SHIFT must be 0..3");
  end

  logic              w_frame_start;
  logic              w_buf_use;
  logic              w_h_in;
  logic              w_v_in;
  logic [9:0]        w_h_clamp;
  logic [9:0]        w_v_clamp;
  logic [CALC_W-1:0] w_addr_sum;

  logic              r_valid_s1;
  logic              r_in_s1;
  logic [9:0]        r_h_s1;
  logic [9:0]        r_v_s1;
  logic [ADDR_W-1:0] r_base_s1;
  logic [ADDR_W-1:0] r_addr;
  logic              r_addr_valid;
  logic              r_in_active;

  assign w_frame_start = (hcount == 10'd0) && (vcount == 10'd0);

  buf_swap_ctrl u_swap (
    .clk          (clk),
    .reset        (reset),
    .i_pix_en     (pix_en),
    .i_frame_start(w_frame_start),
    .i_swap_req   (swap_req),
    .o_buf_sel    (buf_sel),
    .o_buf_use_c  (w_buf_use),
    .o_swap_ack   (swap_ack)
  );

  // Out-of-range coordinates clamp to 0 independently per axis.
  assign w_h_in = {1'b0, hcount} < 11'(H_ACTIVE);
  assign w_v_in = {1'b0, vcount} < 11'(V_ACTIVE);

`ifdef FRAME_ADDR_MIRROR_EN
  assign w_h_clamp = w_h_in ? (10'(H_ACTIVE - 1) - hcount) : 10'd0;
`else
  assign w_h_clamp = w_h_in ? hcount : 10'd0;
`endif
  assign w_v_clamp = w_v_in ? vcount : 10'd0;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_valid_s1 <= 1'b0;
      r_in_s1    <= 1'b0;
      r_h_s1     <= '0;
      r_v_s1     <= '0;
      r_base_s1  <= '0;
    end else begin
      r_valid_s1 <= pix_en;
      if (pix_en) begin
        r_in_s1   <= w_h_in & w_v_in;
        r_h_s1    <= w_h_clamp >> SCALE_SHIFT;
        r_v_s1    <= w_v_clamp >> SCALE_SHIFT;
        r_base_s1 <= w_buf_use ? ADDR_W'(FRAME_WORDS) : '0;
      end
    end
  end

  assign w_addr_sum = CALC_W'(r_base_s1) + (CALC_W'(r_v_s1) * CALC_W'(H_STRIDE))
                    + CALC_W'(r_h_s1);

  // Idle cycles drop addr_valid but hold the last address and range flag.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_addr       <= '0;
      r_addr_valid <= 1'b0;
      r_in_active  <= 1'b0;
    end else begin
      r_addr_valid <= r_valid_s1;
      if (r_valid_s1) begin
        r_addr      <= ADDR_W'(w_addr_sum);
        r_in_active <= r_in_s1;
      end
    end
  end

  assign addr       = r_addr;
  assign addr_valid = r_addr_valid;
  assign in_active  = r_in_active;

endmodule
